// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the data memory (slave).
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues data-memory requests, formats load data and
// registers the result into the MEM/WB boundary.
//
// state | meaning
// IDLE  | accepting instructions from execute
// REQ   | access outstanding, waiting for ack or timeout
module mem_stage #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] ALUResult,
  input  logic [31:0] readData2,
  input  logic [2:0]  funct3,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        mem_stall,
  mem_stage_if.master dmem,
  output logic        out_valid,
  output logic [31:0] out_ALUResult,
  output logic [31:0] out_memReadData,
  output logic        out_fault
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [31:0] TO_LAST = TIMEOUT - 1;

  state_t      state;
  logic [31:0] tcnt;
  logic [31:0] lat_addr;
  logic [2:0]  lat_f3;
  logic        lat_load;

  logic        memop;
  logic        unsupported;
  logic        misaligned;
  logic        bad;
  logic        to_hit;
  logic [31:0] wdata_n;
  logic [3:0]  wstrb_n;

  function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                           input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'd0, b};
      3'b101:  fmt_load = {16'd0, h};
      default: fmt_load = w;
    endcase
  endfunction

  assign memop = in_valid & (MemRead | MemWrite);

  always_comb begin
    unsupported = 1'b0;
    misaligned  = 1'b0;
    if (MemRead)
      unsupported = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else
      unsupported = !(funct3 inside {3'b000, 3'b001, 3'b010});
    if (funct3[1:0] == 2'b01)
      misaligned = ALUResult[0];
    else if (funct3[1:0] == 2'b10)
      misaligned = |ALUResult[1:0];
  end

  assign bad = (MemRead & MemWrite) | unsupported | misaligned;

  // Lane replication lets the memory pick bytes purely from wstrb.
  always_comb begin
    wdata_n = readData2;
    wstrb_n = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata_n = {4{readData2[7:0]}};
        wstrb_n = 4'b0001 << ALUResult[1:0];
      end
      2'b01: begin
        wdata_n = {2{readData2[15:0]}};
        wstrb_n = 4'b0011 << ALUResult[1:0];
      end
      default: ;
    endcase
  end

  assign to_hit = (TIMEOUT != 0) && (tcnt == TO_LAST);

  always_comb begin
    if (state == IDLE)
      mem_stall = memop & !bad;
    else
      mem_stall = !dmem.ack & !to_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      tcnt            <= 32'd0;
      lat_addr        <= 32'd0;
      lat_f3          <= 3'd0;
      lat_load        <= 1'b0;
      dmem.req        <= 1'b0;
      dmem.we         <= 1'b0;
      dmem.addr       <= 32'd0;
      dmem.wdata      <= 32'd0;
      dmem.wstrb      <= 4'd0;
      out_valid       <= 1'b0;
      out_ALUResult   <= 32'd0;
      out_memReadData <= 32'd0;
      out_fault       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= 32'd0;
          if (memop && !bad) begin
            state      <= REQ;
            dmem.req   <= 1'b1;
            dmem.we    <= MemWrite;
            dmem.addr  <= {ALUResult[31:2], 2'b00};
            dmem.wdata <= wdata_n;
            dmem.wstrb <= MemWrite ? wstrb_n : 4'd0;
            lat_addr   <= ALUResult;
            lat_f3     <= funct3;
            lat_load   <= MemRead;
            out_valid  <= 1'b0;
          end else if (in_valid) begin
            out_valid       <= 1'b1;
            out_ALUResult   <= ALUResult;
            out_memReadData <= 32'd0;
            out_fault       <= memop;
          end else begin
            out_valid <= 1'b0;
          end
        end
        REQ: begin
          if (dmem.ack || to_hit) begin
            state           <= IDLE;
            dmem.req        <= 1'b0;
            dmem.we         <= 1'b0;
            dmem.wstrb      <= 4'd0;
            out_valid       <= 1'b1;
            out_ALUResult   <= lat_addr;
            out_fault       <= !dmem.ack;
            out_memReadData <= (dmem.ack && lat_load) ?
                               fmt_load(dmem.rdata, lat_f3, lat_addr[1:0]) : 32'd0;
          end else begin
            tcnt      <= tcnt + 32'd1;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage. It consumes the ALU result as the effective address, readData2 as store data, and funct3 as the access size.
- Drives a req/ack data-memory port and formats load data (byte lanes, sign/zero extension).
- Raises a stall to hold upstream stages while an access is outstanding.
- Registers its result into the MEM/WB boundary for writeback.

Parameters:
TIMEOUT, 256, max cycles dmem_req may stay high without dmem_ack before the access is aborted; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  execute stage presents a valid instruction
ALUResult  input  32  effective address / ALU result
readData2  input  32  store data (rs2)
funct3  input  3  Instruction[14:12], access size/sign
MemRead  input  1  instruction is a load
MemWrite  input  1  instruction is a store
mem_stall  output  1  hold upstream stages this cycle (combinational)
dmem_req  output  1  memory request, registered
dmem_we  output  1  1=write, 0=read
dmem_addr  output  32  word address ({ALUResult[31:2],2'b00})
dmem_wdata  output  32  lane-replicated store data
dmem_wstrb  output  4  byte enables; 0000 on reads
dmem_ack  input  1  memory completes access this cycle
dmem_rdata  input  32  read word, valid when dmem_ack=1
out_valid  output  1  MEM/WB result valid, registered
out_ALUResult  output  32  ALUResult passed through
out_memReadData  output  32  formatted load data
out_fault  output  1  misaligned / illegal / timed-out access

Behaviour:
- **Reset (async, rst_n=0):**
  - state=IDLE, timeout counter=0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0.
  - out_valid=0, out_ALUResult=0, out_memReadData=0, out_fault=0.
  - Reset mid-access drops dmem_req immediately; the access is abandoned with no result.
- **States:** IDLE, REQ.
- **memop and fault definitions:**
  - memop = in_valid & (MemRead|MemWrite).
  - bad = (MemRead&MemWrite) | unsupported funct3 | misaligned.
  - Supported load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Supported store funct3: 000 SB, 001 SH, 010 SW.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- **IDLE:**
  - in_valid & !memop: at the next edge, out_valid=1, out_ALUResult=ALUResult, out_memReadData=0, out_fault=0. No stall.
  - memop & bad: no memory access and no stall. At the next edge, out_valid=1, out_fault=1, out_memReadData=0.
  - memop & !bad: mem_stall=1 this cycle. At the edge, latch the request, set dmem_req=1, go to REQ.
  - !in_valid: at the next edge, out_valid=0. The other out_* hold their values.
- **REQ:**
  - mem_stall = !dmem_ack.
  - dmem_* held stable until ack.
  - Timeout counter increments each cycle without ack.
  - On dmem_ack, at the edge:
    - dmem_req=0, dmem_wstrb=0, state=IDLE.
    - out_valid=1, out_fault=0, out_ALUResult=latched address.
    - out_memReadData = formatted rdata for loads, 0 for stores.
    - Upstream advances on the same edge, since stall was low in the ack cycle.
  - Timeout (TIMEOUT≠0, counter reaches TIMEOUT-1 with no ack): at the edge, dmem_req=0, out_valid=1, out_fault=1, state=IDLE. mem_stall=0 in that cycle.
  - Any late ack arriving in IDLE is ignored.
  - in_valid and the other inputs are ignored while in REQ; upstream holds them because mem_stall=1.
- **Timing:**
  - Latency: non-memory instructions take 1 cycle.
  - Memory access: in_valid at cycle T, dmem_req visible at T+1, ack at T+1+n, out_valid at T+2+n.
  - Back-to-back memops: dmem_req is low for at least one cycle between accesses.
- **Store lane rules** (a = addr[1:0]):
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001<<a.
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011<<a.
  - SW: wdata = rs2, wstrb = 1111.
- **Load formatting:**
  - Select the byte at a, or the halfword at a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

Test Plan:
- **ALU instruction:** ALU op with ALUResult=0x0000_1234, MemRead=MemWrite=0 -> next cycle out_valid=1, out_ALUResult=0x1234, mem_stall never high, dmem_req stays 0.
- **LB with wait states:** LB, addr=0x103, ack after 3 wait cycles, rdata=0x80FF_FF12 -> dmem_addr=0x100, wstrb=0000; mem_stall high 4 cycles; out_memReadData=0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- **SH:** addr=0x202, rs2=0xDEAD_BEEF, immediate ack -> dmem_we=1, wdata=0xBEEF_BEEF, wstrb=1100; out_valid exactly 2 cycles after in_valid.
- **Misaligned LW:** LW, addr=0x301 -> no dmem_req, no stall; next cycle out_valid=1, out_fault=1. Same for MemRead=MemWrite=1 and for funct3=011.
- **Timeout:** TIMEOUT=4, dmem_ack tied 0 -> dmem_req high exactly 4 cycles; then out_valid=1, out_fault=1, stall drops. A late ack afterwards has no effect.
- **Reset mid-access:** rst_n pulsed low while in REQ -> dmem_req=0 and all outputs 0 immediately (asynchronous); after release, a fresh SW completes normally.
